// File: rtl/demo_chan_regbank.sv
// demo_chan_regbank: Wishbone-classic register bank of NCHAN channel blocks plus a read-only RAM window.
// Define DEMO_CHAN_REGBANK_ERR_EN to answer unmapped accesses with wb_err_o instead of a zero-data ack.
module demo_chan_regbank #(
  parameter int          NCHAN      = 4,
  parameter int          ADDR_W     = 14,
  parameter logic [31:0] PRESET_VAL = 32'h00000123,
  parameter int          RAM_DEPTH  = 16,
  localparam int         RW         = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_dat_o,
  output logic [NCHAN-1:0]      ctrl_en_o,
  output logic [4*NCHAN-1:0]    ctrl_mode_o,
  output logic [3*NCHAN-1:0]    ctrl_sel_o,
  output logic [32*NCHAN-1:0]   preset_o,
  output logic [NCHAN-1:0]      cmd_pulse_o,
  output logic [8*NCHAN-1:0]    cmd_code_o,
  input  logic [32*NCHAN-1:0]   status_i,
  input  logic                  ram_we_i,
  input  logic [RW-1:0]         ram_adr_i,
  input  logic [31:0]           ram_dat_i
);
`ifdef DEMO_CHAN_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RAMRD, RESP} state_t;
  state_t              state;
  logic [31:0]         mem [RAM_DEPTH];
  logic [31:0]         ram_q;
  logic [31:0]         reg_rd;
  logic [ADDR_W-5:0]   ch, l_ch;
  logic [1:0]          off, l_off;
  logic                is_ram, hit, req;
  logic                l_ram, l_hit, l_we;
  logic [3:0]          l_sel;
  logic [31:0]         l_dat;
  logic                unused_ok;
  assign unused_ok = ^wb_adr_i[1:0];
  assign ch        = wb_adr_i[ADDR_W-2:4];
  assign off       = wb_adr_i[3:2];
  assign is_ram    = wb_adr_i[ADDR_W-1];
  assign hit       = is_ram ? 32'(wb_adr_i[ADDR_W-2:2]) < RAM_DEPTH : 32'(ch) < NCHAN;
  assign req       = state == IDLE && wb_cyc_i && wb_stb_i;
  always_comb begin
    reg_rd = '0;
    for (int c = 0; c < NCHAN; c++)
      if (32'(ch) == c)
        reg_rd = off == 2'd0 ? {21'd0, ctrl_sel_o[3*c +: 3], ctrl_mode_o[4*c +: 4], 3'd0, ctrl_en_o[c]} :
                 off == 2'd1 ? preset_o[32*c +: 32] :
                 off == 2'd2 ? status_i[32*c +: 32] : '0;
  end
  // RAM is read-first and unreset; the bus read is captured on the cycle the strobe is taken.
  always_ff @(posedge clk_i) begin
    if (ram_we_i) mem[ram_adr_i] <= ram_dat_i;
    if (req) ram_q <= mem[wb_adr_i[RW+1:2]];
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_en_o   <= '0;
      ctrl_mode_o <= '0;
      ctrl_sel_o  <= {NCHAN{3'h2}};
      preset_o    <= {NCHAN{PRESET_VAL}};
      cmd_pulse_o <= '0;
      cmd_code_o  <= '0;
      l_ch        <= '0;
      l_off       <= '0;
      l_ram       <= 1'b0;
      l_hit       <= 1'b0;
      l_we        <= 1'b0;
      l_sel       <= '0;
      l_dat       <= '0;
    end else begin
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      cmd_pulse_o <= '0;
      case (state)
        IDLE: if (req) begin
          l_ch  <= ch;
          l_off <= off;
          l_ram <= is_ram;
          l_hit <= hit;
          l_we  <= wb_we_i;
          l_sel <= wb_sel_i;
          l_dat <= wb_dat_i;
          if (hit && is_ram && !wb_we_i) state <= RAMRD;
          else begin
            state    <= RESP;
            wb_ack_o <= hit || !ERR_EN;
            wb_err_o <= ERR_EN && !hit;
            wb_dat_o <= hit && !is_ram && !wb_we_i ? reg_rd : '0;
          end
        end
        RAMRD: if (!wb_cyc_i) state <= IDLE;
        else begin
          state    <= RESP;
          wb_ack_o <= 1'b1;
          wb_dat_o <= ram_q;
        end
        RESP: begin
          state <= IDLE;
          for (int c = 0; c < NCHAN; c++)
            if (l_we && l_hit && !l_ram && 32'(l_ch) == c) begin
              if (l_off == 2'd0 && l_sel[0]) begin
                ctrl_en_o[c]          <= l_dat[0];
                ctrl_mode_o[4*c +: 4] <= l_dat[7:4];
              end
              if (l_off == 2'd0 && l_sel[1]) ctrl_sel_o[3*c +: 3] <= l_dat[10:8];
              for (int b = 0; b < 4; b++)
                if (l_off == 2'd1 && l_sel[b]) preset_o[32*c+8*b +: 8] <= l_dat[8*b +: 8];
              if (l_off == 2'd3) begin
                cmd_pulse_o[c] <= 1'b1;
                if (l_sel[0]) cmd_code_o[8*c +: 8] <= l_dat[7:0];
              end
            end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_demo_chan_regbank.sv
// tb_demo_chan_regbank: directed plus randomized bus/user traffic against a behavioural register-map model.
module tb_demo_chan_regbank;
  localparam int NCHAN = 4;
  localparam int RD    = 16;
`ifdef DEMO_CHAN_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [13:0]         wb_adr_i = '0;
  logic [3:0]          wb_sel_i = '0;
  logic [31:0]         wb_dat_i = '0;
  logic                wb_ack_o, wb_err_o;
  logic [31:0]         wb_dat_o;
  logic [NCHAN-1:0]    ctrl_en_o, cmd_pulse_o;
  logic [4*NCHAN-1:0]  ctrl_mode_o;
  logic [3*NCHAN-1:0]  ctrl_sel_o;
  logic [32*NCHAN-1:0] preset_o;
  logic [8*NCHAN-1:0]  cmd_code_o;
  logic [32*NCHAN-1:0] status_i = '0;
  logic                ram_we_i = 1'b0;
  logic [3:0]          ram_adr_i = '0;
  logic [31:0]         ram_dat_i = '0;
  logic [31:0] m_ctrl [NCHAN];
  logic [31:0] m_pre  [NCHAN];
  logic [7:0]  m_code [NCHAN];
  logic [31:0] m_ram  [RD];
  int checks = 0, errors = 0;
  demo_chan_regbank dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_dat_o(wb_dat_o), .ctrl_en_o(ctrl_en_o), .ctrl_mode_o(ctrl_mode_o), .ctrl_sel_o(ctrl_sel_o),
    .preset_o(preset_o), .cmd_pulse_o(cmd_pulse_o), .cmd_code_o(cmd_code_o), .status_i(status_i),
    .ram_we_i(ram_we_i), .ram_adr_i(ram_adr_i), .ram_dat_i(ram_dat_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCHAN; c++) begin
      m_ctrl[c] = 32'h200;
      m_pre[c]  = 32'h123;
      m_code[c] = 8'h00;
    end
  endtask
  task automatic check_outs(input string tag);
    logic [NCHAN-1:0]    en;
    logic [4*NCHAN-1:0]  md;
    logic [3*NCHAN-1:0]  sl;
    logic [32*NCHAN-1:0] pr;
    logic [8*NCHAN-1:0]  cd;
    for (int c = 0; c < NCHAN; c++) begin
      en[c]        = m_ctrl[c][0];
      md[4*c +: 4] = m_ctrl[c][7:4];
      sl[3*c +: 3] = m_ctrl[c][10:8];
      pr[32*c +: 32] = m_pre[c];
      cd[8*c +: 8] = m_code[c];
    end
    check({tag, ".en"}, ctrl_en_o, en);
    check({tag, ".mode"}, ctrl_mode_o, md);
    check({tag, ".sel"}, ctrl_sel_o, sl);
    check({tag, ".preset"}, preset_o, pr);
    check({tag, ".code"}, cmd_code_o, cd);
  endtask
  task automatic uwrite(input logic [3:0] a, input logic [31:0] d);
    ram_we_i = 1'b1; ram_adr_i = a; ram_dat_i = d;
    @(posedge clk_i); #1;
    ram_we_i = 1'b0;
    m_ram[a] = d;
  endtask
  // One bus transfer; uw adds user writes to RAM[5] on the strobe cycle and the one after it.
  task automatic xfer(input string tag, input bit w, input logic [13:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit uw);
    int n, c, o, i;
    bit hit, isram;
    logic [31:0] ed, m;
    logic [NCHAN-1:0] ep;
    isram = a[13];
    c = int'(a[12:4]);
    o = int'(a[3:2]);
    i = int'(a[12:2]);
    hit = isram ? i < RD : c < NCHAN;
    ed = '0;
    if (hit && !w)
      ed = isram ? m_ram[i] : o == 0 ? m_ctrl[c] : o == 1 ? m_pre[c] : o == 2 ? status_i[32*c +: 32] : 32'h0;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ep = '0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = w; wb_adr_i = a; wb_sel_i = s; wb_dat_i = d;
    if (uw) begin ram_we_i = 1'b1; ram_adr_i = 4'd5; ram_dat_i = 32'h1; end
    @(posedge clk_i); #1;
    if (uw) ram_dat_i = 32'h2;
    n = 1;
    while (!(wb_ack_o || wb_err_o) && n < 6) begin
      @(posedge clk_i); #1;
      ram_we_i = 1'b0;
      n++;
    end
    ram_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check({tag, ".lat"}, n, (hit && isram && !w) ? 2 : 1);
    check({tag, ".ack"}, wb_ack_o, hit || !ERR_EN);
    check({tag, ".err"}, wb_err_o, ERR_EN && !hit);
    if (wb_ack_o && !w) check({tag, ".rdata"}, wb_dat_o, ed);
    if (w && hit && !isram) begin
      if (o == 0) m_ctrl[c] = ((m_ctrl[c] & ~m) | (d & m)) & 32'h7F1;
      if (o == 1) m_pre[c] = (m_pre[c] & ~m) | (d & m);
      if (o == 3) begin
        ep[c] = 1'b1;
        if (s[0]) m_code[c] = d[7:0];
      end
    end
    if (uw) m_ram[5] = 32'h2;
    @(posedge clk_i); #1;
    check({tag, ".quiet"}, {wb_ack_o, wb_err_o, wb_dat_o}, '0);
    check({tag, ".pulse"}, cmd_pulse_o, ep);
    check_outs(tag);
    @(posedge clk_i); #1;
    check({tag, ".pulse_off"}, cmd_pulse_o, '0);
  endtask
  initial begin
    logic [13:0] a;
    logic [3:0]  s;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst.bus", {wb_ack_o, wb_err_o, wb_dat_o, cmd_pulse_o}, '0);
    check_outs("rst");
    rst_n_i = 1'b1;
    for (int i = 0; i < RD; i++) uwrite(4'(i), $urandom);
    for (int c = 0; c < NCHAN; c++) begin
      status_i[32*c +: 32] = $urandom;
      xfer("t1.ctrl", 1'b0, 14'(16*c), 4'hF, '0, 1'b0);
      xfer("t1.pre", 1'b0, 14'(16*c + 4), 4'hF, '0, 1'b0);
      xfer("t1.stat", 1'b0, 14'(16*c + 8), 4'hF, '0, 1'b0);
    end
    xfer("t2.wr", 1'b1, 14'h20, 4'b0011, 32'hFFFFFFFF, 1'b0);
    xfer("t2.rd", 1'b0, 14'h20, 4'hF, '0, 1'b0);
    check("t2.val", m_ctrl[2], 32'h7F1);
    xfer("t2.sel0", 1'b1, 14'h24, 4'b0000, 32'hFFFFFFFF, 1'b0);
    xfer("t3.cmd", 1'b1, 14'h1C, 4'hF, 32'hA5, 1'b0);
    check("t3.code", cmd_code_o[15:8], 8'hA5);
    xfer("t3.rd", 1'b0, 14'h1C, 4'hF, '0, 1'b0);
    uwrite(4'd5, 32'hDEADBEEF);
    xfer("t4.rd", 1'b0, 14'h2014, 4'hF, '0, 1'b0);
    xfer("t4.rdfirst", 1'b0, 14'h2014, 4'hF, '0, 1'b1);
    xfer("t4.after", 1'b0, 14'h2014, 4'hF, '0, 1'b0);
    xfer("t4.wr_ign", 1'b1, 14'h2014, 4'hF, 32'h5555, 1'b0);
    xfer("t4.after_wr", 1'b0, 14'h2014, 4'hF, '0, 1'b0);
    xfer("t5.ch", 1'b0, 14'h40, 4'hF, '0, 1'b0);
    xfer("t5.ram", 1'b0, 14'h2040, 4'hF, '0, 1'b0);
    xfer("t5.wr", 1'b1, 14'h40, 4'hF, 32'h1234, 1'b0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 14'h2004;
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      check("abort.noack", {wb_ack_o, wb_err_o}, '0);
    end
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 14'h2008;
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    check("t6.noack", {wb_ack_o, wb_err_o}, '0);
    model_reset();
    check_outs("t6");
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("t6.quiet", {wb_ack_o, wb_err_o}, '0);
    xfer("t6.rd", 1'b0, 14'h20, 4'hF, '0, 1'b0);
    for (int k = 0; k < 150; k++) begin
      for (int c = 0; c < NCHAN; c++) status_i[32*c +: 32] = $urandom;
      case ($urandom_range(0, 2))
        0:       a = {1'b0, 9'($urandom_range(0, 5)), 2'($urandom), 2'b00};
        1:       a = {1'b1, 11'($urandom_range(0, 19)), 2'b00};
        default: a = 14'($urandom);
      endcase
      s = 4'($urandom);
      if (!a[13] && a[3:2] == 2'd3) s[0] = 1'b1;
      xfer("rnd", 1'($urandom), a, s, $urandom, 1'b0);
      if ($urandom_range(0, 1) == 1) uwrite(4'($urandom), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/demo_chan_regbank.md
Name: demo_chan_regbank

Overview:
- Parametrised multi-channel successor to the single-instance demo register map.
- Wishbone-classic slave, 32-bit data, byte addresses.
- Implements NCHAN identical register blocks (CTRL, PRESET, STATUS, CMD) plus a read-only RAM window that user logic writes.
- Sits between the bus crossbar and per-channel datapath logic; fixed wait-state handshake, unmapped-access handling.

Parameters:
- NCHAN, 4, number of channels; legal range 1..512.
- ADDR_W, 14, byte-address width; the map spans 0x0..0x3FFF.
- PRESET_VAL, 32'h00000123, reset value of every channel's PRESET register.
- RAM_DEPTH, 16, words in the RAM window; power of 2, 1..1024.

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, synchronous and active-low.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- wb_sel_i  in  4  byte enables.
- wb_dat_i  in  32  write data.
- wb_ack_o  out  1  transfer ack, one-cycle pulse.
- wb_err_o  out  1  error response, one-cycle pulse.
- wb_dat_o  out  32  read data; valid only while ack.
- ctrl_en_o  out  NCHAN  CTRL bit0 per channel.
- ctrl_mode_o  out  4*NCHAN  CTRL[7:4] per channel.
- ctrl_sel_o  out  3*NCHAN  CTRL[10:8] per channel.
- preset_o  out  32*NCHAN  PRESET register per channel.
- cmd_pulse_o  out  NCHAN  one-cycle pulse on a CMD write.
- cmd_code_o  out  8*NCHAN  CMD[7:0], held from the last CMD write.
- status_i  in  32*NCHAN  per-channel status, sampled on read.
- ram_we_i  in  1  user-side RAM write enable.
- ram_adr_i  in  clog2(RAM_DEPTH)  user-side RAM write address.
- ram_dat_i  in  32  user-side RAM write data.

Behaviour:
- Address map:
  - Channel c base = c*0x10.
  - +0x0 CTRL, RW. Implemented bits 0, 7:4, 10:8; other bits read 0. Reset: bit0=0, mode=0, sel=3'h2.
  - +0x4 PRESET, RW. Reset PRESET_VAL.
  - +0x8 STATUS, RO. Returns status_i slice; writes are acked and ignored.
  - +0xC CMD, WO. Reads return 0.
  - RAM window at 0x2000 + 4*i, i < RAM_DEPTH. Read-only from the bus; writes are acked and ignored.
- Mapped = channel index < NCHAN, or RAM index < RAM_DEPTH. Everything else is unmapped.
- FSM states IDLE, RAMRD, RESP:
  - IDLE: on cyc&stb, decode and latch address/we/sel/data.
    - Register access -> RESP next cycle (ack 1 cycle after stb sampled).
    - RAM read -> RAMRD (synchronous RAM, 1 cycle) -> RESP (ack 2 cycles after stb sampled).
  - RESP: ack or err high exactly one cycle, then IDLE. stb is not sampled while in RESP, so min spacing is 2 cycles (register) and 3 cycles (RAM).
  - cyc dropping in RAMRD: abort to IDLE, no ack.
- Writes commit on the RESP cycle:
  - Byte-masked by sel; sel=0 writes nothing but still acks.
  - CMD write: cmd_pulse_o[c]=1 on the cycle after RESP, one cycle only; cmd_code_o updates on RESP when sel[0]=1.
- Reset values: all outputs per the register resets above; ack/err/pulse=0; wb_dat_o=0; FSM=IDLE.
  - rst_n_i low mid-transaction drops the transfer with no ack; registers reload.
- RAM:
  - Read-first: a user write and a bus read of the same address in the same cycle return old data.
  - Simultaneous user writes every cycle never stall the bus.
  - RAM content is not cleared by reset.
- wb_dat_o = 0 outside ack cycles.

Optional Feature:
- DEMO_CHAN_REGBANK_ERR_EN defined: unmapped access -> wb_err_o pulse in RESP, ack stays 0, no side effects.
- Undefined: unmapped access -> wb_ack_o with read data 0, writes discarded; wb_err_o tied 0.

Test Plan:
1. Reset release, read CTRL/PRESET of channels 0..3 -> 0x200 and 0x123 each, ack 1 cycle after stb.
2. Write 0xFFFFFFFF sel=4'b0011 to ch2 CTRL (0x20) -> reads back 0x7F1; ctrl_en_o[2]=1, mode=4'hF, sel=3'h7; other channels unchanged.
3. Write 0xA5 to ch1 CMD (0x1C) -> single cmd_pulse_o[1] cycle after ack, cmd_code_o[15:8]=0xA5; read 0x1C -> 0.
4. User writes 0xDEADBEEF to RAM[5]; bus reads 0x2014 -> 0xDEADBEEF with ack 2 cycles after stb. Same-cycle user write 0x1 to RAM[5] during bus read -> bus sees 0xDEADBEEF.
5. Read 0x40 with NCHAN=4 and 0x2040 with RAM_DEPTH=16 -> err pulse when DEMO_CHAN_REGBANK_ERR_EN is defined, else ack with data 0.
6. Assert rst_n_i in RAMRD cycle -> no ack/err; registers back to reset values next cycle.
